// File: rtl/panda_pulse_pkg.sv
// ============================================================================
// Module   : panda_pulse_pkg
// Brief    : Shared constants, FSM state type and queue entry for the pulse queue
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package panda_pulse_pkg;

  localparam int MIN_DELAY  = 4;
  localparam int MIN_WIDTH  = 1;
  localparam int TW_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HIGH  = 2'd2,
    ST_ERROR = 2'd3
  } pulse_state_t;

  typedef struct packed {
    logic [TW_DEFAULT-1:0] fire;
    logic [TW_DEFAULT-1:0] width;
  } pulse_entry_t;

endpackage

`default_nettype wire

// File: rtl/panda_pulse_queue_if.sv
// ============================================================================
// Module   : panda_pulse_queue_if
// Brief    : Control/status bundle of the pulse queue (trigger, timing, status)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface panda_pulse_queue_if #(
  parameter int TW          = 32,
  parameter int QUEUE_DEPTH = 16
);
  localparam int QW = $clog2(QUEUE_DEPTH) + 1;

  logic          inp_i;
  logic          enable_i;
  logic [TW-1:0] DELAY;
  logic [TW-1:0] WIDTH;
  logic          FORCE_RST;
  logic          out_o;
  logic          perr_o;
  logic [QW-1:0] QUEUE;
  logic [TW-1:0] MISSED_CNT;

  modport master (
    output inp_i, enable_i, DELAY, WIDTH, FORCE_RST,
    input  out_o, perr_o, QUEUE, MISSED_CNT
  );

  modport slave (
    input  inp_i, enable_i, DELAY, WIDTH, FORCE_RST,
    output out_o, perr_o, QUEUE, MISSED_CNT
  );
endinterface

`default_nettype wire

// File: rtl/panda_pulse_fifo.sv
// ============================================================================
// Module   : panda_pulse_fifo
// Brief    : First-word fall-through FIFO with flush; power-of-2 depth
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module panda_pulse_fifo #(
  parameter  int DEPTH = 16,
  parameter  int DW    = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk_i,
  input  wire logic          reset_n_i,
  input  wire logic          i_push,
  input  wire logic          i_pop,
  input  wire logic          i_flush,
  input  wire logic [DW-1:0] i_data,
  output logic      [DW-1:0] o_head,
  output logic      [AW:0]   o_count,
  output logic               o_full,
  output logic               o_empty
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/panda_pulse_queue.sv
// ============================================================================
// Module   : panda_pulse_queue
// Brief    : Schedules one DELAY/WIDTH pulse per rising edge of inp_i via a FIFO
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module panda_pulse_queue
  import panda_pulse_pkg::*;
#(
  parameter int QUEUE_DEPTH = 16,
  parameter int TW          = 32
) (
  input wire logic           clk_i,
  input wire logic           reset_n_i,
  panda_pulse_queue_if.slave bus
);

  localparam int QW = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic [TW-1:0] fire;
    logic [TW-1:0] width;
  } entry_t;

  pulse_state_t  r_state;
  pulse_state_t  w_state_nxt;
  logic [TW-1:0] r_ts;
  logic [TW-1:0] r_last_end;
  logic [TW-1:0] r_missed;
  logic          r_last_valid;
  logic          r_inp_d;
  logic          r_perr;

  logic [TW-1:0] w_d;
  logic [TW-1:0] w_w;
  logic [TW-1:0] w_fire;
  logic [TW-1:0] w_gap;
  logic [TW-1:0] w_head_end;
  entry_t        w_head;
  entry_t        w_new;
  logic [QW-1:0] w_count;
  logic          w_edge;
  logic          w_live;
  logic          w_overlap;
  logic          w_accept;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic          w_hit;
  logic          w_pop;
  logic          w_overflow;
  logic          w_flush;
  logic          w_remain;

  assign w_d    = (bus.DELAY < TW'(MIN_DELAY)) ? TW'(MIN_DELAY) : bus.DELAY;
  assign w_w    = (bus.WIDTH < TW'(MIN_WIDTH)) ? TW'(MIN_WIDTH) : bus.WIDTH;
  assign w_fire = r_ts + w_d;
  assign w_new  = '{fire: w_fire, width: w_w};

  assign w_edge = bus.inp_i & ~r_inp_d;
  assign w_live = w_edge & bus.enable_i & ~bus.FORCE_RST & ~r_perr;

  // Sign of the modular difference orders two timestamps across a ts wrap.
  assign w_gap     = w_fire - r_last_end;
  assign w_overlap = r_last_valid & w_gap[TW-1];
  assign w_accept  = w_live & ~w_overlap;
  assign w_drop    = w_live & w_overlap;

  assign w_head_end = w_head.fire + w_head.width;
  assign w_hit      = ~w_empty & ((r_ts - w_head.fire) < w_head.width);
  assign w_pop      = w_hit & (r_ts == (w_head_end - TW'(1)));
  assign w_overflow = w_accept & w_full & ~w_pop;
  assign w_flush    = bus.FORCE_RST | ~bus.enable_i | w_overflow;
  assign w_remain   = (w_count > QW'(1)) | w_accept;

  panda_pulse_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .DW    (2 * TW)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .i_push    (w_accept & ~w_overflow),
    .i_pop     (w_pop),
    .i_flush   (w_flush),
    .i_data    (w_new),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.FORCE_RST) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_ERROR) begin
      w_state_nxt = ST_ERROR;
    end else if (w_overflow) begin
      w_state_nxt = ST_ERROR;
    end else if (!bus.enable_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (w_pop)      w_state_nxt = w_remain ? ST_WAIT : ST_IDLE;
          else if (w_hit) w_state_nxt = ST_HIGH;
        end
        ST_HIGH: begin
          // A contiguous successor keeps w_hit asserted, so out_o shows no gap.
          if (w_pop) w_state_nxt = w_remain ? ST_WAIT : ST_IDLE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ts         <= '0;
      r_inp_d      <= 1'b0;
      r_perr       <= 1'b0;
      r_missed     <= '0;
      r_last_valid <= 1'b0;
      r_last_end   <= '0;
    end else begin
      r_ts    <= r_ts + TW'(1);
      r_inp_d <= bus.inp_i;
      if (bus.FORCE_RST) begin
        r_perr   <= 1'b0;
        r_missed <= '0;
      end else begin
        if (w_overflow) r_perr <= 1'b1;
        if (w_drop && (r_missed != '1)) r_missed <= r_missed + TW'(1);
      end
      // Once ts reaches the last end, no future fire can overlap it.
      if (w_flush) begin
        r_last_valid <= 1'b0;
      end else if (w_accept) begin
        r_last_valid <= 1'b1;
        r_last_end   <= w_fire + w_w;
      end else if (r_ts == r_last_end) begin
        r_last_valid <= 1'b0;
      end
    end
  end

  assign bus.out_o      = w_hit & (r_state != ST_ERROR);
  assign bus.perr_o     = r_perr;
  assign bus.QUEUE      = w_count;
  assign bus.MISSED_CNT = r_missed;

endmodule

`default_nettype wire

// File: tb/tb_panda_pulse_queue.sv
// ============================================================================
// Module   : tb_panda_pulse_queue
// Brief    : Directed plus random stimulus against a queue-of-pulses model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_panda_pulse_queue;

  localparam int TW = 32;
  localparam int QD = 4;

  typedef struct {
    longint fire;
    longint w;
  } pulse_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  panda_pulse_queue_if #(.TW(TW), .QUEUE_DEPTH(QD)) bus ();

  panda_pulse_queue #(.QUEUE_DEPTH(QD), .TW(TW)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  pulse_t mq[$];
  int     k;
  bit     m_perr;
  longint m_missed;
  bit     m_last_valid;
  longint m_last_end;
  bit     m_inp_prev;
  int     n_checks;
  int     n_errors;
  int     hi_cnt;
  int     q_peak;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at ts=%0d: got %0h, expected %0h", tag, k, got, exp);
    end
  endtask

  function automatic bit m_out();
    foreach (mq[i]) begin
      if (mq[i].fire <= k && k < mq[i].fire + mq[i].w) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Applies the inputs present during cycle k to the model.
  task automatic model_step();
    bit     edge_s;
    bit     pop;
    longint d;
    longint w;
    longint f;
    edge_s = bus.inp_i && !m_inp_prev;
    m_inp_prev = bus.inp_i;
    if (bus.FORCE_RST) begin
      mq.delete();
      m_perr = 0;
      m_missed = 0;
      m_last_valid = 0;
    end else if (m_perr) begin
      // edges ignored while the error is latched
    end else if (!bus.enable_i) begin
      mq.delete();
      m_last_valid = 0;
    end else begin
      pop = (mq.size() > 0) && (k == mq[0].fire + mq[0].w - 1);
      if (edge_s) begin
        d = (longint'(bus.DELAY) < 4) ? 4 : longint'(bus.DELAY);
        w = (longint'(bus.WIDTH) < 1) ? 1 : longint'(bus.WIDTH);
        f = k + d;
        if (m_last_valid && f < m_last_end) begin
          if (m_missed < 64'hFFFF_FFFF) m_missed++;
        end else if (mq.size() == QD && !pop) begin
          m_perr = 1;
          mq.delete();
          pop = 0;
          m_last_valid = 0;
        end else begin
          mq.push_back('{fire: f, w: w});
          m_last_valid = 1;
          m_last_end = f + w;
        end
      end
      if (pop) void'(mq.pop_front());
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    k++;
    check("out_o", bus.out_o, m_out());
    check("perr_o", bus.perr_o, m_perr);
    check("QUEUE", bus.QUEUE, mq.size());
    check("MISSED_CNT", bus.MISSED_CNT, m_missed);
    if (bus.out_o) hi_cnt++;
    if (int'(bus.QUEUE) > q_peak) q_peak = int'(bus.QUEUE);
  endtask

  task automatic do_reset();
    bus.inp_i = 1'b0;
    bus.FORCE_RST = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_out_o", bus.out_o, 0);
    check("rst_perr_o", bus.perr_o, 0);
    check("rst_QUEUE", bus.QUEUE, 0);
    check("rst_MISSED_CNT", bus.MISSED_CNT, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete();
    m_perr = 0;
    m_missed = 0;
    m_last_valid = 0;
    m_last_end = 0;
    m_inp_prev = 0;
    k = 0;
    hi_cnt = 0;
    q_peak = 0;
  endtask

  task automatic run_until(input int t);
    while (k < t) tick();
  endtask

  task automatic edge_at(input int t);
    run_until(t);
    bus.inp_i = 1'b1;
    tick();
    bus.inp_i = 1'b0;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    k = 0;
    bus.inp_i = 1'b0;
    bus.enable_i = 1'b1;
    bus.DELAY = '0;
    bus.WIDTH = '0;
    bus.FORCE_RST = 1'b0;
    #2;

    // Single pulse
    do_reset();
    bus.DELAY = 10;
    bus.WIDTH = 3;
    edge_at(100);
    run_until(130);
    check("single_hi_cycles", hi_cnt, 3);
    check("single_queue_peak", q_peak, 1);

    // Minimum clamp
    do_reset();
    bus.DELAY = 0;
    bus.WIDTH = 0;
    edge_at(50);
    run_until(53);
    check("clamp_low_53", bus.out_o, 0);
    tick();
    check("clamp_high_54", bus.out_o, 1);
    run_until(70);
    check("clamp_hi_cycles", hi_cnt, 1);

    // Queued edges
    do_reset();
    bus.DELAY = 20;
    bus.WIDTH = 2;
    edge_at(100);
    edge_at(105);
    edge_at(110);
    run_until(140);
    check("queued_hi_cycles", hi_cnt, 6);
    check("queued_queue_peak", q_peak, 3);

    // Overlap drop
    do_reset();
    bus.DELAY = 10;
    bus.WIDTH = 8;
    edge_at(100);
    edge_at(104);
    run_until(130);
    check("overlap_hi_cycles", hi_cnt, 8);
    check("overlap_missed", bus.MISSED_CNT, 1);
    check("overlap_perr", bus.perr_o, 0);

    // Back-to-back: second fire equals first end
    do_reset();
    bus.DELAY = 10;
    bus.WIDTH = 4;
    edge_at(100);
    edge_at(104);
    run_until(130);
    check("contig_hi_cycles", hi_cnt, 8);

    // Overflow, then FORCE_RST recovery
    do_reset();
    bus.DELAY = 1000;
    bus.WIDTH = 1;
    for (int i = 0; i < 5; i++) edge_at(100 + 4 * i);
    run_until(118);
    check("ovf_perr", bus.perr_o, 1);
    check("ovf_queue", bus.QUEUE, 0);
    run_until(1110);
    check("ovf_no_pulse", hi_cnt, 0);
    bus.FORCE_RST = 1'b1;
    tick();
    bus.FORCE_RST = 1'b0;
    check("frst_perr", bus.perr_o, 0);
    bus.DELAY = 10;
    edge_at(1120);
    run_until(1140);
    check("frst_hi_cycles", hi_cnt, 1);

    // Asynchronous reset mid-pulse
    do_reset();
    bus.DELAY = 10;
    bus.WIDTH = 8;
    edge_at(100);
    run_until(112);
    check("mid_pulse_high", bus.out_o, 1);
    do_reset();

    // Enable drop with two pending entries
    bus.DELAY = 20;
    bus.WIDTH = 2;
    edge_at(100);
    edge_at(105);
    run_until(118);
    check("en_pending", bus.QUEUE, 2);
    bus.enable_i = 1'b0;
    tick();
    check("en_flush_queue", bus.QUEUE, 0);
    bus.enable_i = 1'b1;
    run_until(150);
    check("en_no_pulse", hi_cnt, 0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 2) == 0) bus.inp_i = ~bus.inp_i;
      if ($urandom_range(0, 15) == 0) bus.DELAY = $urandom_range(0, 24);
      if ($urandom_range(0, 15) == 0) bus.WIDTH = $urandom_range(0, 5);
      bus.enable_i  = ($urandom_range(0, 149) != 0);
      bus.FORCE_RST = ($urandom_range(0, 299) == 0);
      tick();
    end
    bus.FORCE_RST = 1'b0;
    bus.enable_i = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
